// File: rtl/elev_pkg.sv
// -----------------------------------------------------------------------------
// elev_pkg
// Shared definitions for the elevator request-latch slice.
//   NUM_FLOORS         number of served floors
//   DB_CYCLES_DEFAULT  default debounce length. Used only when the
//                      BTN_DEBOUNCE_EN macro is defined.
//   floor_t            2-bit floor index, 0 = floor 1
//   floor_state_e      floor-tracking FSM states
//   count_ones()       population count of a sensor vector
//   onehot_index()     index of the set bit in a one-hot sensor vector
// -----------------------------------------------------------------------------
package elev_pkg;

    localparam int NUM_FLOORS        = 4;
    localparam int DB_CYCLES_DEFAULT = 4;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        UNKNOWN  = 2'd0,
        AT_FLOOR = 2'd1,
        BETWEEN  = 2'd2,
        FAULT    = 2'd3
    } floor_state_e;

    function automatic logic [2:0] count_ones(input logic [NUM_FLOORS-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic floor_t onehot_index(input logic [NUM_FLOORS-1:0] v);
        floor_t idx;
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (v[i]) begin
                idx = floor_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One call-button channel. It holds a 2-flop synchronizer, an optional
// debounce counter and the pending-request bit.
// Optional feature: define BTN_DEBOUNCE_EN to add a 4-bit saturating debounce
// counter. The pending bit then sets only after DB_CYCLES consecutive
// synchronized-high cycles.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   btn    raw asynchronous button level
//   clr    service clear for this floor. It wins over a simultaneous set.
//   pend   registered pending-request bit
// -----------------------------------------------------------------------------
module btn_channel
    import elev_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic pend
);

    logic sync_q1;
    logic sync_q2;
    logic set_req;

    // NOTE: the synchronizer flops are reset too, so a button held through
    // reset cannot reach the pending bit before the third edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            // NOTE: non-blocking keeps the two stages a true shift register.
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam logic [3:0] DB_THRESH = 4'(DB_CYCLES);

    logic [3:0] db_cnt;

    // Counts consecutive synchronized-high cycles and saturates at 15.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt <= '0;
        end else if (!sync_q2) begin
            db_cnt <= '0;
        end else if (db_cnt != 4'hF) begin
            db_cnt <= db_cnt + 4'd1;
        end
    end

    // The registered count reaches DB_CYCLES one edge after the last
    // qualifying sample. The total latency is therefore 2 + DB_CYCLES edges.
    assign set_req = (db_cnt >= DB_THRESH);
`else
    localparam int unused_db_cycles = DB_CYCLES;

    assign set_req = sync_q2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
        end else if (clr) begin
            pend <= 1'b0;
        end else if (set_req) begin
            pend <= 1'b1;
        end
    end

endmodule

// File: rtl/request_latch.sv
// -----------------------------------------------------------------------------
// request_latch
// Latches elevator hall and car calls until the car services the floor. It
// also tracks the car position from the floor sensors.
// Optional feature: define BTN_DEBOUNCE_EN to debounce every button channel
// for DB_CYCLES cycles. Sensors are never debounced.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   sensor[3:0]  floor sensors. Bit i means the car is level with floor i+1.
//   hall_up[3:0] up-call buttons. Bit 3 is ignored (top floor).
//   hall_dn[3:0] down-call buttons. Bit 0 is ignored (bottom floor).
//   car_call[3:0] in-car floor buttons
//   open_door    door-open command, already in the clk domain
//   req_up/req_dn/req_car[3:0]  pending-request bits
//   any_req      OR of all pending bits (combinational)
//   floor[1:0]   last valid floor index
//   floor_valid  car is level with exactly one floor (AT_FLOOR)
//   sensor_err   sticky illegal-sensor flag, cleared only by reset
// -----------------------------------------------------------------------------
module request_latch
    import elev_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] sensor,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    input  logic [NUM_FLOORS-1:0] car_call,
    input  logic                  open_door,
    output logic [NUM_FLOORS-1:0] req_up,
    output logic [NUM_FLOORS-1:0] req_dn,
    output logic [NUM_FLOORS-1:0] req_car,
    output logic                  any_req,
    output logic [1:0]            floor,
    output logic                  floor_valid,
    output logic                  sensor_err
);

    logic [NUM_FLOORS-1:0] sensor_q1;
    logic [NUM_FLOORS-1:0] sensor_q2;
    logic [2:0]            sensor_ones;
    logic [NUM_FLOORS-1:0] clr_floor;
    floor_state_e          state;

    // There is no up call on the top floor and no down call on the bottom
    // floor. These button bits are deliberately left unused.
    logic unused_btns;
    assign unused_btns = hall_up[NUM_FLOORS-1] | hall_dn[0];

    // Bare 2-flop synchronizer for the sensor vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sensor_q1 <= '0;
            sensor_q2 <= '0;
        end else begin
            sensor_q1 <= sensor;
            sensor_q2 <= sensor_q1;
        end
    end

    assign sensor_ones = count_ones(sensor_q2);

    // Floor tracker. A multi-hot sensor vector is checked first, so it
    // overrides every other transition. FAULT can be left only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= UNKNOWN;
            floor       <= '0;
            floor_valid <= 1'b0;
            sensor_err  <= 1'b0;
        end else if (state != FAULT) begin
            if (sensor_ones > 3'd1) begin
                state       <= FAULT;
                floor_valid <= 1'b0;
                sensor_err  <= 1'b1;
            end else if (sensor_ones == 3'd1) begin
                state       <= AT_FLOOR;
                floor       <= onehot_index(sensor_q2);
                floor_valid <= 1'b1;
            end else if (state == AT_FLOOR) begin
                state       <= BETWEEN;
                floor_valid <= 1'b0;
            end
        end
    end

    // floor_valid is low in FAULT, which also blocks service clears there.
    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_clr
        assign clr_floor[i] = open_door & floor_valid & (floor == floor_t'(i));
    end

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
        btn_channel #(.DB_CYCLES(DB_CYCLES)) u_car (
            .clk   (clk),
            .reset (reset),
            .btn   (car_call[i]),
            .clr   (clr_floor[i]),
            .pend  (req_car[i])
        );

        if (i != NUM_FLOORS - 1) begin : g_up
            btn_channel #(.DB_CYCLES(DB_CYCLES)) u_up (
                .clk   (clk),
                .reset (reset),
                .btn   (hall_up[i]),
                .clr   (clr_floor[i]),
                .pend  (req_up[i])
            );
        end else begin : g_no_up
            assign req_up[i] = 1'b0;
        end

        if (i != 0) begin : g_dn
            btn_channel #(.DB_CYCLES(DB_CYCLES)) u_dn (
                .clk   (clk),
                .reset (reset),
                .btn   (hall_dn[i]),
                .clr   (clr_floor[i]),
                .pend  (req_dn[i])
            );
        end else begin : g_no_dn
            assign req_dn[i] = 1'b0;
        end
    end

    assign any_req = |{req_up, req_dn, req_car};

endmodule

// File: tb/tb_request_latch.sv
// -----------------------------------------------------------------------------
// tb_request_latch
// Directed self-checking bench for request_latch. Inputs change 1 ns after a
// rising edge, and outputs are compared at that same point. Expected values
// are hand-computed constants. Button latency follows BTN_DEBOUNCE_EN with
// DB_CYCLES = 4.
// -----------------------------------------------------------------------------
module tb_request_latch;

`ifdef BTN_DEBOUNCE_EN
    localparam int LAT = 6;   // 2 sync edges + 4 debounce edges
    localparam int PW  = 4;   // shortest press that is accepted
`else
    localparam int LAT = 2;
    localparam int PW  = 1;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] sensor;
    logic [3:0] hall_up;
    logic [3:0] hall_dn;
    logic [3:0] car_call;
    logic       open_door;
    logic [3:0] req_up;
    logic [3:0] req_dn;
    logic [3:0] req_car;
    logic       any_req;
    logic [1:0] floor;
    logic       floor_valid;
    logic       sensor_err;

    int checks = 0;
    int errors = 0;

    request_latch #(.DB_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor      (sensor),
        .hall_up     (hall_up),
        .hall_dn     (hall_dn),
        .car_call    (car_call),
        .open_door   (open_door),
        .req_up      (req_up),
        .req_dn      (req_dn),
        .req_car     (req_car),
        .any_req     (any_req),
        .floor       (floor),
        .floor_valid (floor_valid),
        .sensor_err  (sensor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        sensor    = 4'b0000;
        hall_up   = 4'b0000;
        hall_dn   = 4'b0000;
        car_call  = 4'b0000;
        open_door = 1'b0;
        tick(2);

        // Reset state
        check("rst_req_up",      req_up,      4'b0000);
        check("rst_req_dn",      req_dn,      4'b0000);
        check("rst_req_car",     req_car,     4'b0000);
        check("rst_any_req",     any_req,     1'b0);
        check("rst_floor",       floor,       2'd0);
        check("rst_floor_valid", floor_valid, 1'b0);
        check("rst_sensor_err",  sensor_err,  1'b0);

        // Ignored buttons held for a long time
        reset   = 1'b1;
        hall_up = 4'b1000;
        hall_dn = 4'b0001;
        tick(12);
        check("ignored_up",  req_up,  4'b0000);
        check("ignored_dn",  req_dn,  4'b0000);
        check("ignored_any", any_req, 1'b0);
        hall_up = 4'b0000;
        hall_dn = 4'b0000;

        // Arrive at floor 1, then a short hall_up[2] press
        sensor = 4'b0001;
        tick(3);
        check("f0_valid", floor_valid, 1'b1);
        check("f0_floor", floor,       2'd0);
        hall_up = 4'b0100;
        tick(PW);
        hall_up = 4'b0000;
        tick(LAT - PW);
        check("up2_not_yet", req_up, 4'b0000);
        tick(1);
        check("up2_set",     req_up,  4'b0100);
        check("up2_any",     any_req, 1'b1);

        // Several calls, then service at floor index 0
        hall_up  = 4'b0001;
        hall_dn  = 4'b0010;
        car_call = 4'b0111;
        tick(PW);
        hall_up  = 4'b0000;
        hall_dn  = 4'b0000;
        car_call = 4'b0000;
        tick(LAT + 1);
        check("pre_svc_up",  req_up,  4'b0101);
        check("pre_svc_dn",  req_dn,  4'b0010);
        check("pre_svc_car", req_car, 4'b0111);
        open_door = 1'b1;
        tick(1);
        open_door = 1'b0;
        check("svc0_up",  req_up,  4'b0100);
        check("svc0_dn",  req_dn,  4'b0010);
        check("svc0_car", req_car, 4'b0110);

        // Re-press hall_up[0], leave the floor, door command while BETWEEN
        hall_up = 4'b0001;
        tick(PW);
        hall_up = 4'b0000;
        tick(LAT + 1);
        check("repress_up", req_up, 4'b0101);
        sensor = 4'b0000;
        tick(3);
        check("between_valid", floor_valid, 1'b0);
        check("between_floor", floor,       2'd0);
        open_door = 1'b1;
        tick(1);
        open_door = 1'b0;
        check("between_noclr_up",  req_up,  4'b0101);
        check("between_noclr_car", req_car, 4'b0110);

        // Arrive at floor index 2 and service it
        sensor = 4'b0100;
        tick(3);
        check("f2_valid", floor_valid, 1'b1);
        check("f2_floor", floor,       2'd2);
        open_door = 1'b1;
        tick(1);
        open_door = 1'b0;
        check("svc2_up",  req_up,  4'b0001);
        check("svc2_dn",  req_dn,  4'b0010);
        check("svc2_car", req_car, 4'b0010);

        // Held button: clear wins on the door edge, bit re-sets next edge
        car_call = 4'b0100;
        tick(LAT + 1);
        check("hold_set", req_car, 4'b0110);
        open_door = 1'b1;
        tick(1);
        open_door = 1'b0;
        check("hold_clr_wins", req_car, 4'b0010);
        tick(1);
        check("hold_reset_bit", req_car, 4'b0110);
        car_call = 4'b0000;
        tick(2);
        check("release_holds", req_car, 4'b0110);

        // Illegal sensor pattern: FAULT, no clears, sticky
        sensor = 4'b0110;
        tick(3);
        check("fault_err",   sensor_err,  1'b1);
        check("fault_valid", floor_valid, 1'b0);
        check("fault_floor", floor,       2'd2);
        open_door = 1'b1;
        tick(1);
        open_door = 1'b0;
        check("fault_noclr_car", req_car, 4'b0110);
        check("fault_noclr_up",  req_up,  4'b0001);
        sensor = 4'b0100;
        tick(4);
        check("fault_sticky_err",   sensor_err,  1'b1);
        check("fault_sticky_valid", floor_valid, 1'b0);

        // Asynchronous reset mid-operation, observed before any edge
        reset = 1'b0;
        #2;
        check("async_rst_car", req_car,    4'b0000);
        check("async_rst_up",  req_up,     4'b0000);
        check("async_rst_dn",  req_dn,     4'b0000);
        check("async_rst_any", any_req,    1'b0);
        check("async_rst_err", sensor_err, 1'b0);

        // Button held through reset: first set no earlier than edge 3
        sensor   = 4'b0001;
        car_call = 4'b0001;
        tick(1);
        reset = 1'b1;
        tick(2);
        check("post_rst_edge2", req_car, 4'b0000);
        tick(LAT - 1);
        check("post_rst_set",   req_car,     4'b0001);
        check("post_rst_valid", floor_valid, 1'b1);
        car_call = 4'b0000;

`ifdef BTN_DEBOUNCE_EN
        // A 3-cycle press is rejected; a 4-cycle press sets at edge 6
        hall_dn = 4'b1000;
        tick(3);
        hall_dn = 4'b0000;
        tick(8);
        check("db_short_press", req_dn, 4'b0000);
        hall_dn = 4'b1000;
        tick(4);
        hall_dn = 4'b0000;
        tick(2);
        check("db_edge5", req_dn, 4'b0000);
        tick(1);
        check("db_edge6", req_dn, 4'b1000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/request_latch.md
REQUEST_LATCH -- requirements
Module: request_latch

Interface
REQ-001 Parameter DB_CYCLES, default 4: consecutive synchronized-high cycles needed to accept a button; used only when BTN_DEBOUNCE_EN is defined; legal range 2..15.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  reset, asynchronous and active-low.
REQ-004 sensor  input  4  floor sensors; bit i high means the car is level with floor i+1.
REQ-005 hall_up  input  4  up-call buttons; bit i is floor i+1.
REQ-006 hall_dn  input  4  down-call buttons; bit i is floor i+1.
REQ-007 car_call  input  4  in-car floor buttons; bit i is floor i+1.
REQ-008 open_door  input  1  door-open command from the controller, same clock domain.
REQ-009 req_up, req_dn, req_car  output  4 each  registered pending-request bits, one per floor.
REQ-010 any_req  output  1  OR of all pending bits.
REQ-011 floor  output  2  last valid floor index, 0 = floor 1.
REQ-012 floor_valid  output  1  car is currently level with exactly one floor.
REQ-013 sensor_err  output  1  sticky flag for an illegal sensor pattern.

Function
REQ-014 Each button and sensor input SHALL pass through a 2-flop synchronizer; open_door SHALL NOT be synchronized.
REQ-015 Without debounce, a button high at edge k SHALL set its pending bit at edge k+2, visible after edge k+2.
REQ-016 A pending bit SHALL stay set after the button is released, until a service clear.
REQ-017 hall_dn[0] and hall_up[3] SHALL be ignored, and their outputs SHALL be constant 0.
REQ-018 Service clear: when open_door=1 and floor_valid=1 at edge k, req_up[floor], req_dn[floor] and req_car[floor] SHALL be 0 after edge k; other floors SHALL be unaffected.
REQ-019 If a set and a clear hit the same bit at the same edge, the clear SHALL win. A button still held SHALL re-set the bit on a later edge where no clear occurs.
REQ-020 open_door with floor_valid=0 SHALL clear nothing.
REQ-021 The floor FSM SHALL have four states: UNKNOWN, AT_FLOOR, BETWEEN and FAULT. Transitions use the synchronized sensor vector:
- UNKNOWN or BETWEEN, exactly one bit set -> AT_FLOOR; floor takes that index.
- AT_FLOOR, all bits zero -> BETWEEN; floor holds.
- AT_FLOOR, a different single bit set -> AT_FLOOR; floor updates.
- Any state, two or more bits set -> FAULT; sensor_err goes to 1.
- FAULT is left only by reset.
REQ-022 floor_valid SHALL be 1 only in AT_FLOOR. In FAULT, floor SHALL hold its last value and no service clears SHALL occur.
REQ-023 any_req SHALL be combinational from the pending registers, so it has zero added latency.

Reset
REQ-024 While reset is low, the following SHALL be 0: all pending bits, all synchronizer flops, all debounce counters, floor, floor_valid and sensor_err. The FSM SHALL be in UNKNOWN.
REQ-025 Reset asserted mid-operation SHALL drop all pending requests immediately, without waiting for a clock edge.
REQ-026 After reset releases, the first pending bit SHALL be able to set no earlier than the third rising edge.

Configuration
REQ-027 Macro BTN_DEBOUNCE_EN defined:
- Each button channel SHALL have a 4-bit saturating counter.
- The pending bit SHALL set only after DB_CYCLES consecutive synchronized-high cycles.
- A synchronized low SHALL zero the counter.
- Latency SHALL be 2+DB_CYCLES edges.
REQ-028 Macro BTN_DEBOUNCE_EN undefined: no counters SHALL exist, and REQ-015 latency SHALL apply. Sensors SHALL never be debounced.

Structure
REQ-029 Shared package elev_pkg SHALL hold:
- NUM_FLOORS = 4;
- the floor index type (2 bits);
- the floor-FSM state enum;
- the default DB_CYCLES.
REQ-030 Sub-module btn_channel SHALL contain the synchronizer, the optional debounce and the pending bit with clear input. It SHALL be instantiated 10 times (the 10 legal buttons); sensors use bare synchronizers.

Verification
REQ-031 Reset, then sensor=0001, then a 1-cycle hall_up[2] pulse -> req_up=0100 after the 2nd edge, any_req=1, floor=0, floor_valid=1.
REQ-032 sensor 0001 -> 0000 -> 0100, then open_door=1 for one cycle with req_car[2] pending -> BETWEEN (floor_valid=0, floor=0), then floor=2; req_car[2] clears and other bits are unchanged.
REQ-033 Hold car_call[1] continuously while at floor 2 and pulse open_door -> the bit clears on the open_door edge, then re-sets on the next edge.
REQ-034 sensor=0110 -> sensor_err=1, floor_valid=0; open_door then clears nothing; after reset, sensor_err=0.
REQ-035 hall_dn[0]=1 and hall_up[3]=1 held for 10 cycles -> req_dn[0]=0, req_up[3]=0, any_req=0.
REQ-036 With BTN_DEBOUNCE_EN and DB_CYCLES=4: a 3-cycle press -> no set; a 4-cycle press -> the bit sets at edge 6 after the press starts.
